// File: rtl/bist_controller.sv
// Per-scan BIST loop sequencer: drives scan/capture/LFSR/MISR controls, counts
// shift cycles and patterns, and latches a sticky pass/fail from the MISR match.
module bist_controller #(
    parameter int CHAIN_LEN    = 32,
    parameter int NUM_PATTERNS = 100
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                misr_match,
    output logic                                scan_enable,
    output logic                                capture,
    output logic                                lfsr_enable,
    output logic                                misr_reset,
    output logic                                misr_enable,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [$clog2(NUM_PATTERNS+1)-1:0]   pattern_count
);

    localparam int PW = $clog2(NUM_PATTERNS + 1);
    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SHIFT, S_CAPTURE, S_UNLOAD, S_COMPARE, S_DONE
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] shift_cnt, shift_cnt_nx;
    logic [PW-1:0] count_nx;
    logic          pass_nx;
    logic          shift_last;
    logic          pattern_last;
    logic          in_run;

    assign shift_last   = (shift_cnt == CW'(CHAIN_LEN - 1));
    assign pattern_last = ((pattern_count + PW'(1)) == PW'(NUM_PATTERNS));
    assign in_run       = (state != S_IDLE) && (state != S_DONE);

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_nx     = state;
        shift_cnt_nx = shift_cnt;
        count_nx     = pattern_count;
        pass_nx      = pass;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_INIT;
                    count_nx = '0;
                    pass_nx  = 1'b0;
                end
            end
            S_INIT: begin
                state_nx     = S_SHIFT;
                shift_cnt_nx = '0;
            end
            S_SHIFT: begin
                if (shift_last) state_nx = S_CAPTURE;
                else            shift_cnt_nx = shift_cnt + CW'(1);
            end
            S_CAPTURE: begin
                count_nx     = pattern_count + PW'(1);
                shift_cnt_nx = '0;
                state_nx     = pattern_last ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                if (shift_last) state_nx = S_COMPARE;
                else            shift_cnt_nx = shift_cnt + CW'(1);
            end
            S_COMPARE: begin
                pass_nx  = misr_match;
                state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase

        // Abort wins over every transition above but leaves the pattern count visible.
        if (abort && in_run) begin
            state_nx     = S_IDLE;
            pass_nx      = 1'b0;
            count_nx     = pattern_count;
            shift_cnt_nx = shift_cnt;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            shift_cnt     <= '0;
            pattern_count <= '0;
            pass          <= 1'b0;
            scan_enable   <= 1'b0;
            capture       <= 1'b0;
            lfsr_enable   <= 1'b0;
            misr_reset    <= 1'b0;
            misr_enable   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nx;
            shift_cnt     <= shift_cnt_nx;
            pattern_count <= count_nx;
            pass          <= pass_nx;
            scan_enable   <= (state_nx == S_SHIFT) || (state_nx == S_UNLOAD);
            capture       <= (state_nx == S_CAPTURE);
            lfsr_enable   <= (state_nx == S_SHIFT);
            misr_reset    <= (state_nx == S_INIT);
            misr_enable   <= ((state_nx == S_SHIFT) && (count_nx != '0)) || (state_nx == S_UNLOAD);
            busy          <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done          <= (state_nx == S_DONE);
        end
    end

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller: each run pushes its expected per-cycle
// control waveform, which is popped and compared as the DUT steps through it.
module tb_bist_controller;

    localparam int CL = 4;
    localparam int NP = 3;
    localparam int PW = $clog2(NP + 1);
    localparam int RUN_BUSY = 1 + NP * (CL + 1) + CL + 1;

    typedef struct {
        logic [6:0] ctl;   // {scan_enable, capture, lfsr_enable, misr_reset, misr_enable, busy, done}
        int         cnt;
        logic       pass;
        bit         is_compare;
    } entry_t;

    logic clock, reset, start, abort, misr_match;
    logic scan_enable, capture, lfsr_enable, misr_reset, misr_enable, busy, done, pass;
    logic [PW-1:0] pattern_count;

    entry_t sb[$];
    int errors = 0;
    int checks = 0;

    bist_controller #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .misr_match(misr_match), .scan_enable(scan_enable), .capture(capture),
        .lfsr_enable(lfsr_enable), .misr_reset(misr_reset), .misr_enable(misr_enable),
        .busy(busy), .done(done), .pass(pass), .pattern_count(pattern_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] ctl_now();
        return {scan_enable, capture, lfsr_enable, misr_reset, misr_enable, busy, done};
    endfunction

    function automatic entry_t mk(logic [6:0] ctl, int cnt, logic p, bit cmp);
        entry_t e;
        e.ctl = ctl; e.cnt = cnt; e.pass = p; e.is_compare = cmp;
        return e;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({ctl_now(), pass, pattern_count} !== '0) begin
            errors++;
            $display("FAIL %s got ctl=%b pass=%b count=%0d required all 0",
                     name, ctl_now(), pass, pattern_count);
        end
    endtask

    // Reference waveform of one complete run, built from the parameters.
    task automatic push_run(input logic exp_pass);
        sb.push_back(mk(7'b0001010, 0, 1'b0, 1'b0));                      // INIT
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < CL; s++)
                sb.push_back(mk({3'b101, 1'b0, (p != 0), 2'b10}, p, 1'b0, 1'b0));
            sb.push_back(mk(7'b0100010, p, 1'b0, 1'b0));                  // CAPTURE
        end
        for (int s = 0; s < CL; s++)
            sb.push_back(mk(7'b1000110, NP, 1'b0, 1'b0));                 // UNLOAD
        sb.push_back(mk(7'b0000010, NP, 1'b0, 1'b1));                     // COMPARE
        sb.push_back(mk(7'b0000001, NP, exp_pass, 1'b0));                 // DONE
    endtask

    // mode 0: match=1, 1: match=0, 2: high only in COMPARE, 3: low only in COMPARE
    task automatic run(input int mode, input int abort_idx, input int start_idx,
                       input int reset_idx, input bit check_busy, input string name);
        entry_t e;
        int idx = 0;
        int busy_cycles = 0;
        push_run(mode == 0 || mode == 2);
        start = 1'b1;
        while (sb.size() > 0) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            e = sb.pop_front();
            checks += 3;
            if (ctl_now() !== e.ctl) begin
                errors++;
                $display("FAIL %s ctl cyc=%0d got=%b required=%b", name, idx, ctl_now(), e.ctl);
            end
            if (int'(pattern_count) !== e.cnt) begin
                errors++;
                $display("FAIL %s pattern_count cyc=%0d got=%0d required=%0d", name, idx, pattern_count, e.cnt);
            end
            if (pass !== e.pass) begin
                errors++;
                $display("FAIL %s pass cyc=%0d got=%b required=%b", name, idx, pass, e.pass);
            end
            if (busy === 1'b1) busy_cycles++;
            unique case (mode)
                0: misr_match = 1'b1;
                1: misr_match = 1'b0;
                2: misr_match = e.is_compare;
                default: misr_match = !e.is_compare;
            endcase
            if (idx == abort_idx) begin
                abort = 1'b1;
                sb.delete();
                sb.push_back(mk(7'b0000000, e.cnt, 1'b0, 1'b0));
            end
            if (idx == start_idx) start = 1'b1;
            if (idx == reset_idx) begin
                #2 reset = 1'b0;
                #1 check_all_zero({name, "_async_reset"});
                sb.delete();
                @(negedge clock) reset = 1'b1;
            end
            idx++;
        end
        if (check_busy) begin
            checks++;
            if (busy_cycles != RUN_BUSY) begin
                errors++;
                $display("FAIL %s busy_cycles got=%0d required=%0d", name, busy_cycles, RUN_BUSY);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; misr_match = 1'b0;
        repeat (3) step();
        check_all_zero("reset_hold");
        start = 1'b1;
        step();
        check_all_zero("reset_ignores_start");
        start = 1'b0;
        @(negedge clock) reset = 1'b1;
        step();
        check_all_zero("reset_release_idle");
    endtask

    task automatic test_full_run();
        run(0, -1, -1, -1, 1'b1, "full_run");
    endtask

    task automatic test_pass_fail();
        run(1, -1, -1, -1, 1'b1, "fail_run");
        run(2, -1, -1, -1, 1'b1, "match_only_compare");
        run(3, -1, -1, -1, 1'b1, "mismatch_only_compare");
    endtask

    task automatic test_back_to_back();
        run(0, -1, -1, -1, 1'b1, "pass_before_restart");
        run(1, -1, -1, -1, 1'b1, "restart_from_done");
    endtask

    task automatic test_abort();
        run(0, 1 + (CL + 1), -1, -1, 1'b0, "abort_second_shift");
        run(0, -1, -1, -1, 1'b1, "run_after_abort");
    endtask

    task automatic test_start_ignored();
        run(0, -1, 3, -1, 1'b1, "start_in_shift");
    endtask

    task automatic test_async_reset();
        run(0, -1, -1, 1 + NP * (CL + 1) + 1, 1'b0, "unload");
        step();
        check_all_zero("idle_after_async_reset");
        run(0, -1, -1, -1, 1'b1, "run_after_async_reset");
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_pass_fail();
        test_back_to_back();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencer for the per-scan BIST loop. It drives scan-enable, capture and the pattern-generator enable, and resets and gates the response MISR. It counts shift cycles and patterns, then samples the MISR's golden-signature match to produce a sticky pass/fail result. It sits between the test-access top level and the scan-chain/LFSR/MISR datapath.

## Interface
- `CHAIN_LEN`, default 32: scan-chain length, i.e. shift cycles per pattern; legal range is ≥ 1.
- `NUM_PATTERNS`, default 100: patterns applied per run; legal range is ≥ 1.
- `clock` in 1: single clock; all flops update on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE and DONE.
- `abort` in 1: stops a run in progress; has priority over everything except `reset`.
- `misr_match` in 1: the MISR's pass_nfail signal (signature equals golden).
- `scan_enable` out 1: chain in shift mode.
- `capture` out 1: one-cycle functional capture strobe.
- `lfsr_enable` out 1: advance the pattern generator.
- `misr_reset` out 1: synchronous, active-high clear to the MISR.
- `misr_enable` out 1: MISR compresses this cycle.
- `busy` out 1: run in progress (any state other than IDLE and DONE).
- `done` out 1: run complete; held high while in DONE.
- `pass` out 1: result of the last completed run; valid while `done` is high.
- `pattern_count` out clog2(NUM_PATTERNS+1): number of patterns captured so far in the current run.

## Operation
- States:
  - IDLE: default state.
  - INIT: one cycle.
  - SHIFT: shift patterns in and responses out.
  - CAPTURE: one cycle.
  - UNLOAD: final flush of the chain.
  - COMPARE: one cycle.
  - DONE: run finished.
- IDLE, `start`=1: go to INIT. Clear `pattern_count`. Clear `pass`.
- INIT: `misr_reset`=1; go to SHIFT and load the shift counter with 0.
- SHIFT: `scan_enable`=1, `lfsr_enable`=1.
  - `misr_enable`=1 only when `pattern_count` ≠ 0. On the first load the chain holds non-response data, so the MISR is not fed.
  - When the shift counter reaches CHAIN_LEN−1, go to CAPTURE. Otherwise increment the counter.
- CAPTURE: `scan_enable`=0, `capture`=1; increment `pattern_count`.
  - If the new count equals NUM_PATTERNS, go to UNLOAD. Otherwise go to SHIFT.
  - The shift counter is cleared on leaving CAPTURE.
- UNLOAD: `scan_enable`=1, `misr_enable`=1, `lfsr_enable`=0. Lasts CHAIN_LEN cycles, then go to COMPARE.
- COMPARE: all datapath controls 0. Register `pass` ← `misr_match`, then go to DONE.
- DONE: `done`=1, and `pass` is held.
  - `start`=1 re-enters INIT directly. This clears `pass`, clears `pattern_count` and drops `done` on the next cycle.
- `abort`=1 in any state from INIT to COMPARE: next state is IDLE. `pass`=0, `done`=0, `pattern_count` is held.
  - In IDLE and DONE, `abort` is ignored.
- `start` in any busy state is ignored.
- Counters never wrap, because transitions occur at exact terminal counts. Terminal-count compares use full counter width.

## Timing
- All outputs are registered. The whole output vector (state decode plus flags) updates on the same edge as the state.
- Reset values: state=IDLE; `scan_enable`, `capture`, `lfsr_enable`, `misr_reset`, `misr_enable`, `busy`, `done`, `pass` all 0; `pattern_count`=0.
- Asynchronous assertion of `reset` forces the reset values immediately, including mid-run. Release is synchronous to `clock` (through the top-level synchroniser).
- `start` sampled at edge k gives INIT (and `busy`=1, `misr_reset`=1) during cycle k+1.
- Run length from INIT entry to DONE entry: 1 + NUM_PATTERNS·(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles.
- `misr_match` is sampled on the edge that ends COMPARE. The MISR's last compressed bit arrives on the final UNLOAD edge, so the match is stable for one full cycle before sampling.
- `capture` is never high in the same cycle as `scan_enable`. `misr_reset` is never high in the same cycle as `misr_enable`.
- `abort` sampled at edge k gives IDLE with all controls 0 in cycle k+1.

## Test plan
- Reset check, with CHAIN_LEN=4 and NUM_PATTERNS=3:
  - Stimulus: hold `reset`=0.
  - Required response: all outputs 0.
- Full run, same parameters:
  - Stimulus: release `reset`, then pulse `start`.
  - Required response: `busy` is high for exactly 21 cycles.
  - `scan_enable` waveform: 4 high, 1 low (`capture`), repeated 3 times; then 4 high (UNLOAD); then COMPARE.
  - `misr_enable` is low during the first 4 shift cycles and high for the next 12 shift/unload cycles.
  - `done`=1 afterwards.
- Pass/fail:
  - Stimulus: tie `misr_match`=1 for one run, then `misr_match`=0 for a second run.
  - Required response: `pass`=1 after the first run and `pass`=0 after the second.
  - Also toggle `misr_match` low everywhere except COMPARE. Required response: `pass` reflects only the COMPARE-cycle value.
- Abort during the second SHIFT:
  - Required response: next cycle is IDLE, all controls 0, `done`=0, `pattern_count`=1.
  - A subsequent `start` runs the full 21 cycles.
- Restart from DONE:
  - Stimulus: `start`=1 while `done`=1.
  - Required response: next cycle has `misr_reset`=1, `done`=0, `pass`=0, `pattern_count`=0.
- Asynchronous reset mid-UNLOAD:
  - Required response: outputs go to 0 without a clock edge.
  - `start` is ignored while `busy`=1. Check by pulsing `start` during SHIFT: there is no re-INIT.
